// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Holds a double-buffered value, steps through the digits with a dead-time gap, and decodes hex.
module seg_scan_ctrl #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_en,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;
  logic [0:0]       state;
  logic [15:0]      active;
  logic [15:0]      pend;
  logic             pend_valid;
  logic [3:0]       dp_q;
  logic             lz_q;
  logic             frame_end;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign frame_end = enable && (state == ST_DRIVE) && (cnt == CNT_LAST) && (digit == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      digit      <= 2'd0;
      state      <= ST_BLANK;
      frame_done <= 1'b0;
      active     <= 16'h0000;
      pend       <= 16'h0000;
      pend_valid <= 1'b0;
    end else if (!enable) begin
      cnt        <= '0;
      digit      <= 2'd0;
      state      <= ST_BLANK;
      frame_done <= 1'b0;
      // Display is dark, so a new value can go straight to the active buffer.
      if (load) begin
        active     <= value;
        pend       <= value;
        pend_valid <= 1'b0;
      end
    end else begin
      frame_done <= frame_end;
      if (state == ST_BLANK) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == BLANK_LAST) state <= ST_DRIVE;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        digit <= digit + 2'd1;
        state <= ST_BLANK;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Swap buffers only between frames; a coincident load is the newest value and wins.
      if (frame_end) begin
        if (load) active <= value;
        else if (pend_valid) active <= pend;
        if (load) pend <= value;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend       <= value;
        pend_valid <= 1'b1;
      end
    end
  end

  // Option inputs are registered so outputs depend on state only.
  always_ff @(posedge clk) begin
    dp_q <= dp_en;
    lz_q <= lz_en;
  end

  logic [3:0] nib;
  logic       supp;
  logic       lit;

  always_comb begin
    nib  = 4'h0;
    supp = 1'b0;
    case (digit)
      2'd0: nib = active[3:0];
      2'd1: begin nib = active[7:4];   supp = lz_q && (active[15:4]  == 12'h000); end
      2'd2: begin nib = active[11:8];  supp = lz_q && (active[15:8]  == 8'h00);   end
      default: begin nib = active[15:12]; supp = lz_q && (active[15:12] == 4'h0); end
    endcase
    lit = (state == ST_DRIVE) && !supp;
    an  = 4'b1111;
    seg = 7'b1111111;
    dp  = 1'b1;
    if (lit) begin
      an  = ~(4'b0001 << digit);
      seg = hex_to_seg(nib);
      dp  = ~dp_q[digit];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic against a frame-position model.
module tb_seg_scan_ctrl;
  localparam int DIV = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [15:0] value = 16'h0000;
  logic load = 1'b0;
  logic lz_en = 1'b0;
  logic [3:0] dp_en = 4'b0000;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  logic frame_done;

  int total = 0;
  int bad = 0;

  // Reference model: position in the frame plus buffer contents.
  int m_pos = 0;
  logic [15:0] m_act = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  logic m_pv = 1'b0;
  logic m_fd = 1'b0;
  logic [3:0] m_dp = 4'b0000;
  logic m_lz = 1'b0;

  seg_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .load(load),
    .lz_en(lz_en), .dp_en(dp_en), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected {an, seg, dp, frame_done} from the model.
  function automatic logic [12:0] exp_out();
    int d;
    int s;
    logic lit;
    logic [3:0] nib;
    d = m_pos / DIV;
    s = m_pos % DIV;
    nib = 4'(m_act >> (4 * d));
    lit = (s >= BLANK_CYC) && !(m_lz && d > 0 && (m_act >> (4 * d)) == 16'h0000);
    if (lit) return {~(4'b0001 << d), hex7(nib), ~m_dp[d], m_fd};
    return {4'b1111, 7'b1111111, 1'b1, m_fd};
  endfunction

  task automatic model_update();
    logic bnd;
    if (!rst_n) begin
      m_pos = 0; m_act = 16'h0000; m_pend = 16'h0000; m_pv = 1'b0; m_fd = 1'b0;
    end else if (!enable) begin
      if (load) begin m_act = value; m_pend = value; m_pv = 1'b0; end
      m_pos = 0;
      m_fd = 1'b0;
    end else begin
      bnd = (m_pos == FRAME - 1);
      m_fd = bnd;
      if (bnd) begin
        if (load) m_act = value;
        else if (m_pv) m_act = m_pend;
        if (load) m_pend = value;
        m_pv = 1'b0;
      end else if (load) begin
        m_pend = value;
        m_pv = 1'b1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    m_dp = dp_en;
    m_lz = lz_en;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; load = 1'b1; value = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        bad++; $display("FAIL reset_hold i=%0d got=%b expected=%b", i, {an, seg, dp, frame_done}, 13'h1FFE);
      end
    end
    rst_n = 1'b1; enable = 1'b0; load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        bad++; $display("FAIL reset_release i=%0d got=%b expected=%b", i, {an, seg, dp, frame_done}, 13'h1FFE);
      end
    end
  endtask

  task automatic test_basic_scan();
    int cm;
    value = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    tick();
    enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      cm = c % FRAME;
      total++;
      if ({an, seg, dp, frame_done} !== exp_out()) begin
        bad++; $display("FAIL basic_model c=%0d got=%b expected=%b", c, {an, seg, dp, frame_done}, exp_out());
      end
      if (cm >= 2 && cm <= 7) begin
        total++;
        if ({an, seg} !== {4'b1110, 7'b0011001}) begin
          bad++; $display("FAIL basic_digit0 c=%0d got=%b expected=%b", c, {an, seg}, {4'b1110, 7'b0011001});
        end
      end
      if (cm >= 10 && cm <= 15) begin
        total++;
        if ({an, seg} !== {4'b1101, 7'b0110000}) begin
          bad++; $display("FAIL basic_digit1 c=%0d got=%b expected=%b", c, {an, seg}, {4'b1101, 7'b0110000});
        end
      end
      total++;
      if (frame_done !== (c == 32)) begin
        bad++; $display("FAIL basic_frame_done c=%0d got=%b expected=%b", c, frame_done, (c == 32));
      end
    end
  endtask

  task automatic test_double_buffer();
    while (m_pos != 10) tick();
    value = 16'hABCD; load = 1'b1; tick(); load = 1'b0;
    for (int c = 0; c < FRAME + (FRAME - 11); c++) begin
      tick();
      total++;
      if ({an, seg, dp, frame_done} !== exp_out()) begin
        bad++; $display("FAIL dbuf_model c=%0d got=%b expected=%b", c, {an, seg, dp, frame_done}, exp_out());
      end
      if (c < FRAME - 11 && an == 4'b1011 && seg !== 7'b0100100) begin
        bad++; $display("FAIL dbuf_old_digit2 c=%0d got=%b expected=%b", c, seg, 7'b0100100);
      end
      if (c < FRAME - 11 && an == 4'b0111 && seg !== 7'b1111001) begin
        bad++; $display("FAIL dbuf_old_digit3 c=%0d got=%b expected=%b", c, seg, 7'b1111001);
      end
      if (c >= FRAME - 11 && an == 4'b1110) begin
        total++;
        if (seg !== 7'b0100001) begin
          bad++; $display("FAIL dbuf_new_digit0 c=%0d got=%b expected=%b", c, seg, 7'b0100001);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    int lit0;
    logic [3:0] seen;
    enable = 1'b0; lz_en = 1'b1; value = 16'h0042; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      total++;
      if ({an, seg, dp, frame_done} !== exp_out() || an[3] === 1'b0 || an[2] === 1'b0) begin
        bad++; $display("FAIL lz_0042 c=%0d got=%b expected=%b", c, {an, seg, dp, frame_done}, exp_out());
      end
    end
    enable = 1'b0; value = 16'h0000; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1;
    lit0 = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      if (an == 4'b1110 && seg == 7'b1000000) lit0++;
      total++;
      if (an !== 4'b1111 && !(an == 4'b1110 && seg == 7'b1000000)) begin
        bad++; $display("FAIL lz_0000 c=%0d got=%b expected=%b", c, {an, seg}, {4'b1110, 7'b1000000});
      end
    end
    total++;
    if (lit0 != DIV - BLANK_CYC) begin
      bad++; $display("FAIL lz_0000_digit0_cycles got=%0d expected=%0d", lit0, DIV - BLANK_CYC);
    end
    enable = 1'b0; lz_en = 1'b0; value = 16'h0042; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1;
    seen = 4'b0000;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      seen = seen | ~an;
      total++;
      if ({an, seg, dp, frame_done} !== exp_out()) begin
        bad++; $display("FAIL lz_off_model c=%0d got=%b expected=%b", c, {an, seg, dp, frame_done}, exp_out());
      end
    end
    total++;
    if (seen !== 4'b1111) begin
      bad++; $display("FAIL lz_off_all_digits got=%b expected=%b", seen, 4'b1111);
    end
  endtask

  task automatic test_decimal_point();
    enable = 1'b0; dp_en = 4'b0100; value = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      total++;
      if (dp !== (an == 4'b1011 ? 1'b0 : 1'b1) || {an, seg, dp, frame_done} !== exp_out()) begin
        bad++; $display("FAIL dp c=%0d got=%b expected=%b", c, {an, seg, dp, frame_done}, exp_out());
      end
    end
    dp_en = 4'b0000;
  endtask

  task automatic test_reset_mid_drive();
    while (m_pos != 2 * DIV + 3) tick();
    total++;
    if (an !== 4'b1011) begin
      bad++; $display("FAIL rst_mid_pre got=%b expected=%b", an, 4'b1011);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    total++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      bad++; $display("FAIL rst_mid_dark got=%b expected=%b", {an, seg, dp, frame_done}, 13'h1FFE);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      total++;
      if ((c >= 2 && c <= 7 && {an, seg} !== {4'b1110, 7'b1000000}) || {an, seg, dp, frame_done} !== exp_out()) begin
        bad++; $display("FAIL rst_mid_restart c=%0d got=%b expected=%b", c, {an, seg, dp, frame_done}, exp_out());
      end
    end
  endtask

  task automatic test_boundary_load();
    while (m_pos != 20) tick();
    value = 16'h9999; load = 1'b1; tick(); load = 1'b0;
    while (m_pos != FRAME - 1) tick();
    value = 16'h5555; load = 1'b1; tick(); load = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      total++;
      if ((an !== 4'b1111 && seg !== 7'b0010010) || {an, seg, dp, frame_done} !== exp_out()) begin
        bad++; $display("FAIL boundary_load c=%0d got=%b expected=%b", c, {an, seg, dp, frame_done}, exp_out());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1200; c++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      load   = ($urandom_range(0, 7) == 0);
      value  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) value[15:8] = 8'h00;
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 15) == 0) dp_en = 4'($urandom);
      tick();
      total++;
      if ({an, seg, dp, frame_done} !== exp_out()) begin
        bad++; $display("FAIL random c=%0d got=%b expected=%b", c, {an, seg, dp, frame_done}, exp_out());
      end
    end
    rst_n = 1'b1; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_double_buffer();
    test_leading_zero();
    test_decimal_point();
    test_reset_mid_drive();
    test_boundary_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
